// File: rtl/spi_master_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_pkg
//   Shared definitions for the SPI controller: FSM state encoding and the
//   SPI mode-0 idle levels. Imported by spi_master and usable by
//   peripheral-side logic and benches.
// -----------------------------------------------------------------------------
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOW   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    // Mode 0: sclk idles low, data sampled on the sclk rising edge.
    localparam logic SCLK_IDLE   = 1'b0;
    localparam logic CS_INACTIVE = 1'b1;
    localparam logic MOSI_RESET  = 1'b0;

endpackage

// File: rtl/spi_master_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
//   Half-period timer for the SPI serial clock. Counts 0..CLKDIV-1 and asserts
//   tick while the count sits at CLKDIV-1, then wraps to 0.
// Ports
//   clk    in  system clock
//   reset  in  asynchronous active-high reset, clears the count
//   clear  in  synchronous restart of the count from 0
//   tick   out high for one cycle every CLKDIV cycles
// -----------------------------------------------------------------------------
module spi_clk_div #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == CW'(CLKDIV - 1));

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Controller end of the SPI link, mode 0. Shifts a width-bit word out on
//   mosi MSB-first, samples miso on each sclk rising edge, and presents the
//   received word on rxData together with a one-cycle done pulse.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | cs high, sclk low, waiting for start
//   LOW    | sclk low half-period, mosi stable for the coming rising edge
//   HIGH   | sclk high half-period, miso already captured
//   TRAIL  | last falling edge done, cs held low one more half-period
//   GAP    | cs high, still busy, enforces minimum deselect time
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-high reset
//   start   in   transfer request, honoured only when not busy
//   txData  in   word to send, captured when start is accepted
//   miso    in   serial data from the peripheral
//   rxData  out  last complete received word
//   busy    out  transfer in progress (through the GAP period)
//   done    out  one-cycle pulse on the first cycle cs is high again
//   sclk    out  serial clock
//   cs      out  chip select, active low
//   mosi    out  serial data to the peripheral
// -----------------------------------------------------------------------------
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned width  = 8,
    parameter int unsigned CLKDIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [width-1:0] txData,
    input  logic             miso,
    output logic [width-1:0] rxData,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             cs,
    output logic             mosi
);

    localparam int unsigned BCW = $clog2(width + 1);

    spi_state_e       state_q;
    logic [width-1:0] tx_shift_q;
    logic [width-1:0] rx_shift_q;
    logic [width-1:0] rx_data_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             sclk_q;
    logic             cs_q;
    logic             mosi_q;

    logic tick;
    logic accept;
    logic div_clear;

    assign accept = (state_q == ST_IDLE) && start;

    // Every non-IDLE tick moves the FSM, so restarting the divider there
    // keeps each phase exactly CLKDIV cycles long.
    assign div_clear = accept || (tick && (state_q != ST_IDLE));

    spi_clk_div #(
        .CLKDIV(CLKDIV)
    ) u_clk_div (
        .clk  (clk),
        .reset(reset),
        .clear(div_clear),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= SCLK_IDLE;
            cs_q       <= CS_INACTIVE;
            mosi_q     <= MOSI_RESET;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        tx_shift_q <= txData;
                        mosi_q     <= txData[width-1];
                        cs_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        bit_cnt_q  <= BCW'(width);
                        state_q    <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tick) begin
                        sclk_q     <= 1'b1;
                        rx_shift_q <= {rx_shift_q[width-2:0], miso};
                        state_q    <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        sclk_q <= 1'b0;
                        if (bit_cnt_q == BCW'(1)) begin
                            state_q <= ST_TRAIL;
                        end else begin
                            // Next bit goes out on the falling edge; mosi
                            // otherwise keeps the last bit until next accept.
                            tx_shift_q <= tx_shift_q << 1;
                            mosi_q     <= tx_shift_q[width-2];
                            bit_cnt_q  <= bit_cnt_q - 1'b1;
                            state_q    <= ST_LOW;
                        end
                    end
                end
                ST_TRAIL: begin
                    if (tick) begin
                        cs_q      <= 1'b1;
                        rx_data_q <= rx_shift_q;
                        done_q    <= 1'b1;
                        state_q   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rxData = rx_data_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign sclk   = sclk_q;
    assign cs     = cs_q;
    assign mosi   = mosi_q;

endmodule
